wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage RV32I pipeline: the writer that drives the register file's write port (`addr_rd`, `data_rd`, `write_enable`). It holds the MEM/WB pipeline register and selects the result source. It aligns and sign- or zero-extends load data, suppresses writes to x0 and faulted loads, and keeps a 64-bit retired-instruction counter. It sits between the MEM stage and the register file; its write-port outputs double as the WB→ID forwarding source.

## Interface
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.
- `REG_ADDR_WIDTH`, 5, register index width.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  MEM stage presents an instruction this cycle.
- `mem_reg_write`  in  1  instruction writes rd.
- `mem_rd_addr`  in  5  destination register.
- `mem_wb_sel`  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- `mem_alu_result`  in  32  ALU result; also the load byte address.
- `mem_load_data`  in  32  raw aligned word from data memory.
- `mem_funct3`  in  3  load width/sign code.
- `mem_pc`  in  32  instruction PC.
- `mem_imm`  in  32  decoded immediate.
- `flush`  in  1  squash the instruction being captured this edge.
- `addr_rd`  out  5  register file write address.
- `data_rd`  out  32  register file write data.
- `write_enable`  out  1  register file write strobe.
- `load_fault`  out  1  current WB instruction is a misaligned or illegal load.
- `wb_pc`  out  32  PC of the instruction in WB.
- `instret`  out  64  count of retired instructions.

## Operation
- **Pipeline register:** on each rising edge the MEM/WB register captures all `mem_*` fields.
  - The valid bit captures `mem_valid & ~flush`.
  - `flush` has priority over `mem_valid`.
  - There is no stall input: an upstream stall is presented as `mem_valid=0`.
- **Result mux**, combinational from the WB register:
  - 00 → alu_result.
  - 01 → formatted load.
  - 10 → pc+4, computed modulo 2^32.
  - 11 → imm.
- **Load formatting:** byte offset is alu_result[1:0].
  - LB (000) / LBU (100): select byte [8*off+7 : 8*off]; sign-extend for LB, zero-extend for LBU.
  - LH (001) / LHU (101): select halfword [16*off[1]+15 : 16*off[1]]; sign-extend for LH, zero-extend for LHU.
  - LW (010): whole word.
- **Load faults:** `load_fault` = valid & wb_sel==01 & (halfword with off[0]=1, or word with off≠0, or funct3 ∈ {011,110,111}).
- **Write strobe:** `write_enable` = valid & reg_write & (rd≠0) & ~load_fault. `addr_rd` carries the rd field and `data_rd` the mux output, even while `write_enable` is 0.
- **Counter:** `instret` increments by 1 on each edge where the WB register holds valid & ~load_fault, including instructions with rd=0 or reg_write=0. It wraps from 2^64−1 to 0.

## Timing
- **Reset** (asynchronous; all values hold while `reset_n`=0):
  - Valid bit cleared.
  - All WB register fields cleared to 0.
  - `instret`=0.
  - Outputs: `write_enable`=0, `load_fault`=0, `addr_rd`=0, `data_rd`=0, `wb_pc`=0.
- **Latency:** an instruction presented with `mem_valid=1` at edge N drives the write port during cycle N→N+1. The register file commits it at edge N+1, and `instret` reflects it after edge N+1.
- **Reset mid-operation:** the instruction in WB is discarded without a write, and no count is recorded.
- **Back-to-back instructions** retire one per cycle with no bubbles.
- **Flush and valid together** at the same edge: the result is a bubble.
- **Outputs** depend only on WB register state. No combinational path exists from `mem_*` or `flush` to any output.

## Test plan
- **Reset then ALU result:** reset, then ALU instruction rd=5, alu_result=0x0000_1234 → one cycle later `write_enable`=1, `addr_rd`=5, `data_rd`=0x1234, `instret`=1 after the next edge.
- **Byte and halfword loads:** load_data=0x80FF_7F01 with addr offsets 0–3:
  - LB off=1 → 0x0000_007F.
  - LB off=2 → 0xFFFF_FFFF.
  - LBU off=3 → 0x0000_0080.
  - LH off=2 → 0xFFFF_80FF.
  - LHU off=0 → 0x0000_7F01.
- **Faults:** LW with offset 2, and funct3=011 → `load_fault`=1, `write_enable`=0, `instret` unchanged.
- **x0 destination:** rd=0 with reg_write=1 → `write_enable`=0 while `instret` still increments. Same for a JAL with pc=0xFFFF_FFFC: `data_rd`=0x0000_0000.
- **Flush:** `flush`=1 together with `mem_valid`=1 → no write the next cycle. `reset_n` dropped mid-stream → outputs are 0 immediately.
- **Counter wrap:** preload `instret` to 2^64−1 via a backdoor, retire one instruction → `instret`=0.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : RV32I writeback stage. Holds the MEM/WB register, formats loads,
//            drives the register-file write port, counts retired instructions.
// Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      mem_valid,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [1:0]                mem_wb_sel,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_load_data,
    input  logic [2:0]                mem_funct3,
    input  logic [DATA_WIDTH-1:0]     mem_pc,
    input  logic [DATA_WIDTH-1:0]     mem_imm,
    input  logic                      flush,
    output logic [REG_ADDR_WIDTH-1:0] addr_rd,
    output logic [DATA_WIDTH-1:0]     data_rd,
    output logic                      write_enable,
    output logic                      load_fault,
    output logic [DATA_WIDTH-1:0]     wb_pc,
    output logic [63:0]               instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic                      valid_q;
    logic                      reg_write_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [1:0]                wb_sel_q;
    logic [DATA_WIDTH-1:0]     alu_q;
    logic [DATA_WIDTH-1:0]     load_q;
    logic [2:0]                funct3_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [63:0]               instret_q;
    logic [63:0]               instret_d;
    logic                      valid_d;

    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] byte_sh;
    logic [DATA_WIDTH-1:0] half_sh;
    logic [DATA_WIDTH-1:0] load_fmt;
    logic [DATA_WIDTH-1:0] result;
    logic                  fault;
    logic                  retire;

    assign valid_d = mem_valid & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            load_q      <= '0;
            funct3_q    <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd_addr;
            wb_sel_q    <= mem_wb_sel;
            alu_q       <= mem_alu_result;
            load_q      <= mem_load_data;
            funct3_q    <= mem_funct3;
            pc_q        <= mem_pc;
            imm_q       <= mem_imm;
            instret_q   <= instret_d;
        end
    end

    // Lane selection by right-shifting the word so the wanted lane lands at bit 0.
    assign off     = alu_q[1:0];
    assign byte_sh = load_q >> {off, 3'b000};
    assign half_sh = load_q >> {off[1], 4'b0000};

    always_comb begin
        load_fmt = load_q;
        case (funct3_q)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]};
            default: load_fmt = load_q;
        endcase
    end

    always_comb begin
        result = imm_q;
        case (wb_sel_q)
            SEL_ALU:  result = alu_q;
            SEL_LOAD: result = load_fmt;
            SEL_PC4:  result = pc_q + DATA_WIDTH'(4);
            default:  result = imm_q;
        endcase
    end

    always_comb begin
        fault = 1'b0;
        if (valid_q && (wb_sel_q == SEL_LOAD)) begin
            case (funct3_q)
                3'b001, 3'b101:         fault = off[0];
                3'b010:                 fault = (off != 2'b00);
                3'b011, 3'b110, 3'b111: fault = 1'b1;
                default:                fault = 1'b0;
            endcase
        end
    end

    // Every valid non-faulting instruction retires, even ones that skip the write.
    assign retire    = valid_q & ~fault;
    assign instret_d = retire ? instret_q + 64'd1 : instret_q;

    assign addr_rd      = rd_q;
    assign data_rd      = result;
    assign write_enable = valid_q & reg_write_q & (rd_q != '0) & ~fault;
    assign load_fault   = fault;
    assign wb_pc        = pc_q;
    assign instret      = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed vector bench for wb_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_pc;
    logic [31:0] mem_imm;
    logic        flush;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        write_enable;
    logic        load_fault;
    logic [31:0] wb_pc;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd_addr    (mem_rd_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_funct3     (mem_funct3),
        .mem_pc         (mem_pc),
        .mem_imm        (mem_imm),
        .flush          (flush),
        .addr_rd        (addr_rd),
        .data_rd        (data_rd),
        .write_enable   (write_enable),
        .load_fault     (load_fault),
        .wb_pc          (wb_pc),
        .instret        (instret)
    );

    typedef struct {
        string       name;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_fault;
        logic        exp_inc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_valid      = 1'b0;
        mem_reg_write  = 1'b0;
        mem_rd_addr    = '0;
        mem_wb_sel     = '0;
        mem_alu_result = '0;
        mem_load_data  = '0;
        mem_funct3     = '0;
        mem_pc         = '0;
        mem_imm        = '0;
        flush          = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
        mem_valid      = 1'b1;
        mem_reg_write  = 1'b1;
        mem_rd_addr    = rd;
        mem_wb_sel     = 2'b00;
        mem_alu_result = val;
        mem_pc         = pc;
    endtask

    task automatic add(input string n, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc, input logic [31:0] imm, input logic cd,
                       input logic [31:0] ed, input logic we, input logic ft, input logic inc);
        vec_t v;
        v.name = n; v.reg_write = rw; v.rd = rd; v.sel = sel; v.f3 = f3; v.alu = alu;
        v.ld = ld; v.pc = pc; v.imm = imm; v.chk_data = cd; v.exp_data = ed;
        v.exp_we = we; v.exp_fault = ft; v.exp_inc = inc;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] LD = 32'h80FF_7F01;

    initial begin
        logic [63:0] base;

        add("alu_rd5",   1, 5'd5,  2'b00, 3'b000, 32'h0000_1234, LD, 32'h100, 0,  1, 32'h0000_1234, 1, 0, 1);
        add("lb_off1",   1, 5'd6,  2'b01, 3'b000, 32'h0000_1001, LD, 32'h104, 0,  1, 32'h0000_007F, 1, 0, 1);
        add("lb_off2",   1, 5'd6,  2'b01, 3'b000, 32'h0000_1002, LD, 32'h108, 0,  1, 32'hFFFF_FFFF, 1, 0, 1);
        add("lb_off0",   1, 5'd6,  2'b01, 3'b000, 32'h0000_1000, LD, 32'h10C, 0,  1, 32'h0000_0001, 1, 0, 1);
        add("lbu_off3",  1, 5'd7,  2'b01, 3'b100, 32'h0000_1003, LD, 32'h110, 0,  1, 32'h0000_0080, 1, 0, 1);
        add("lh_off2",   1, 5'd8,  2'b01, 3'b001, 32'h0000_1002, LD, 32'h114, 0,  1, 32'hFFFF_80FF, 1, 0, 1);
        add("lhu_off0",  1, 5'd9,  2'b01, 3'b101, 32'h0000_1000, LD, 32'h118, 0,  1, 32'h0000_7F01, 1, 0, 1);
        add("lhu_off2",  1, 5'd9,  2'b01, 3'b101, 32'h0000_1002, LD, 32'h11C, 0,  1, 32'h0000_80FF, 1, 0, 1);
        add("lw_off0",   1, 5'd10, 2'b01, 3'b010, 32'h0000_1000, LD, 32'h120, 0,  1, 32'h80FF_7F01, 1, 0, 1);
        add("lw_off2",   1, 5'd10, 2'b01, 3'b010, 32'h0000_1002, LD, 32'h124, 0,  0, 32'h0,         0, 1, 0);
        add("f3_011",    1, 5'd11, 2'b01, 3'b011, 32'h0000_1000, LD, 32'h128, 0,  0, 32'h0,         0, 1, 0);
        add("lh_off1",   1, 5'd11, 2'b01, 3'b001, 32'h0000_1001, LD, 32'h12C, 0,  0, 32'h0,         0, 1, 0);
        add("f3_110",    1, 5'd11, 2'b01, 3'b110, 32'h0000_1000, LD, 32'h130, 0,  0, 32'h0,         0, 1, 0);
        add("alu_x0",    1, 5'd0,  2'b00, 3'b000, 32'h0000_5555, LD, 32'h134, 0,  1, 32'h0000_5555, 0, 0, 1);
        add("jal_x0",    1, 5'd0,  2'b10, 3'b000, 32'h0,         LD, 32'hFFFF_FFFC, 0, 1, 32'h0,   0, 0, 1);
        add("jal_rd1",   1, 5'd1,  2'b10, 3'b000, 32'h0,         LD, 32'h0000_2000, 0, 1, 32'h2004, 1, 0, 1);
        add("lui_rd7",   1, 5'd7,  2'b11, 3'b000, 32'h0,         LD, 32'h138, 32'hABCD_E000, 1, 32'hABCD_E000, 1, 0, 1);
        add("no_rw",     0, 5'd3,  2'b00, 3'b000, 32'h0000_0042, LD, 32'h13C, 0,  1, 32'h0000_0042, 0, 0, 1);
        add("fault_x0",  1, 5'd0,  2'b01, 3'b111, 32'h0000_1000, LD, 32'h140, 0,  0, 32'h0,         0, 1, 0);

        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_we",      {63'd0, write_enable}, 64'd0);
        check("rst_fault",   {63'd0, load_fault},   64'd0);
        check("rst_addr",    {59'd0, addr_rd},      64'd0);
        check("rst_data",    {32'd0, data_rd},      64'd0);
        check("rst_pc",      {32'd0, wb_pc},        64'd0);
        check("rst_instret", instret,               64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            base           = instret;
            mem_valid      = 1'b1;
            mem_reg_write  = vecs[i].reg_write;
            mem_rd_addr    = vecs[i].rd;
            mem_wb_sel     = vecs[i].sel;
            mem_funct3     = vecs[i].f3;
            mem_alu_result = vecs[i].alu;
            mem_load_data  = vecs[i].ld;
            mem_pc         = vecs[i].pc;
            mem_imm        = vecs[i].imm;
            @(negedge clock);
            drive_idle();
            check({vecs[i].name, "_we"},    {63'd0, write_enable}, {63'd0, vecs[i].exp_we});
            check({vecs[i].name, "_fault"}, {63'd0, load_fault},   {63'd0, vecs[i].exp_fault});
            check({vecs[i].name, "_addr"},  {59'd0, addr_rd},      {59'd0, vecs[i].rd});
            check({vecs[i].name, "_pc"},    {32'd0, wb_pc},        {32'd0, vecs[i].pc});
            if (vecs[i].chk_data)
                check({vecs[i].name, "_data"}, {32'd0, data_rd}, {32'd0, vecs[i].exp_data});
            check({vecs[i].name, "_instret_hold"}, instret, base);
            @(negedge clock);
            check({vecs[i].name, "_instret"}, instret, base + {63'd0, vecs[i].exp_inc});
            check({vecs[i].name, "_bubble_we"}, {63'd0, write_enable}, 64'd0);
        end

        // Back-to-back: three instructions, one retired per cycle.
        base = instret;
        drive_alu(5'd12, 32'h0000_0AAA, 32'h200);
        @(negedge clock);
        check("b2b0_data", {32'd0, data_rd}, 64'h0AAA);
        drive_alu(5'd13, 32'h0000_0BBB, 32'h204);
        @(negedge clock);
        check("b2b1_data", {32'd0, data_rd}, 64'h0BBB);
        check("b2b1_we",   {63'd0, write_enable}, 64'd1);
        check("b2b1_cnt",  instret, base + 64'd1);
        drive_alu(5'd14, 32'h0000_0CCC, 32'h208);
        @(negedge clock);
        drive_idle();
        check("b2b2_addr", {59'd0, addr_rd}, 64'd14);
        check("b2b2_cnt",  instret, base + 64'd2);
        @(negedge clock);
        check("b2b_final_cnt", instret, base + 64'd3);

        // Flush together with valid produces a bubble.
        base = instret;
        drive_alu(5'd15, 32'h0000_0F0F, 32'h300);
        flush = 1'b1;
        @(negedge clock);
        drive_idle();
        check("flush_we", {63'd0, write_enable}, 64'd0);
        @(negedge clock);
        check("flush_cnt", instret, base);

        // Asynchronous reset mid-stream clears outputs immediately.
        drive_alu(5'd16, 32'h0000_7777, 32'h400);
        @(negedge clock);
        drive_idle();
        check("pre_rst_we", {63'd0, write_enable}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_we",      {63'd0, write_enable}, 64'd0);
        check("midrst_addr",    {59'd0, addr_rd},      64'd0);
        check("midrst_data",    {32'd0, data_rd},      64'd0);
        check("midrst_pc",      {32'd0, wb_pc},        64'd0);
        check("midrst_instret", instret,               64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_instret", instret, 64'd0);

        // Counter wrap through a backdoor preload.
        drive_alu(5'd17, 32'h0000_0001, 32'h500);
        @(negedge clock);
        drive_idle();
        dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock);
        check("wrap_zero", instret, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
